// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Provides the word, register-number and ALU-op types used across the
// pipeline, the ID/EX latch state enum, and the control bundle carried by
// the ID/EX and EX/MEM pipeline registers.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int AOP_W  = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [AOP_W-1:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // RUN: normal operation. HALTED: a halt instruction has entered EX;
    // only reset leaves this state.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } latch_state_t;

    // Decoded control bundle, shared by the ID/EX and EX/MEM latches.
    typedef struct packed {
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   aluSrc;
        logic   halt;
        aluop_t aluop;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_latch_if.sv
// Interface bundling the ID/EX latch ports.
//   latch modport : the pipeline register's view (ID side in, EX side out)
//   tb modport    : the driver/observer view (ID side out, EX side in)
interface id_ex_latch_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic       CLK;
    logic       nRST;
    logic       ihit;
    logic       mem_wait;
    logic       flush;
    logic       id_valid;
    regbits_t   id_rs;
    regbits_t   id_rt;
    regbits_t   id_dest;
    logic       id_usesRt;
    logic       id_regWrite;
    logic       id_memRead;
    logic       id_memWrite;
    logic       id_aluSrc;
    logic       id_halt;
    aluop_t     id_aluop;
    word_t      id_imm;
    word_t      id_pc;
    word_t      id_opA;
    word_t      id_opB;
    logic       ex_valid;
    logic       ex_regWrite;
    logic       ex_memRead;
    logic       ex_memWrite;
    logic       ex_aluSrc;
    logic       ex_halt;
    regbits_t   ex_rs;
    regbits_t   ex_rt;
    regbits_t   ex_dest;
    aluop_t     ex_aluop;
    word_t      ex_imm;
    word_t      ex_pc;
    word_t      ex_opA;
    word_t      ex_opB;
    logic       id_hold;
    logic [CNT_W-1:0] bubble_cnt;

    modport latch (
        input  CLK, nRST, ihit, mem_wait, flush, id_valid,
        input  id_rs, id_rt, id_dest, id_usesRt,
        input  id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_halt, id_aluop,
        input  id_imm, id_pc, id_opA, id_opB,
        output ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_halt,
        output ex_rs, ex_rt, ex_dest, ex_aluop,
        output ex_imm, ex_pc, ex_opA, ex_opB,
        output id_hold, bubble_cnt
    );

    modport tb (
        output CLK, nRST, ihit, mem_wait, flush, id_valid,
        output id_rs, id_rt, id_dest, id_usesRt,
        output id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_halt, id_aluop,
        output id_imm, id_pc, id_opA, id_opB,
        input  ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_halt,
        input  ex_rs, ex_rt, ex_dest, ex_aluop,
        input  ex_imm, ex_pc, ex_opA, ex_opB,
        input  id_hold, bubble_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags an instruction in ID that reads the destination of a load still in
// EX; the loaded value is not available for forwarding until after MEM.
//   ex_valid, ex_memRead, ex_dest : the instruction currently in EX
//   id_valid, id_rs, id_rt,
//   id_usesRt                     : the instruction currently in ID
//   lu                            : ID must wait one cycle
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_memRead,
    input  regbits_t ex_dest,
    input  logic     id_valid,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_usesRt,
    output logic     lu
);

    logic rs_match;
    logic rt_match;

    // Register zero is hard-wired, so a load targeting it never creates a hazard.
    assign rs_match = (ex_dest == id_rs);
    assign rt_match = id_usesRt & (ex_dest == id_rt);
    assign lu       = ex_valid & ex_memRead & (ex_dest != '0)
                    & (rs_match | rt_match) & id_valid;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register.
// Captures the decoded instruction and its forwarded operands into EX,
// inserts bubbles on flush, load-use hazard, empty ID or after a halt, holds
// everything while the pipeline is frozen (no ihit or MEM waiting), tracks a
// sticky halt state and counts flush/load-use bubbles.
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit, mem_wait       : advance when ihit & ~mem_wait
//   flush                : squash the instruction in ID
//   id_*                 : decoded instruction and forwarded operands
//   ex_*                 : registered copy presented to EX
//   id_hold              : IF/ID must not advance (load-use or halted)
//   bubble_cnt           : saturating count of flush/load-use bubbles
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             mem_wait,
    input  logic             flush,
    input  logic             id_valid,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  regbits_t         id_dest,
    input  logic             id_usesRt,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_memWrite,
    input  logic             id_aluSrc,
    input  logic             id_halt,
    input  aluop_t           id_aluop,
    input  word_t            id_imm,
    input  word_t            id_pc,
    input  word_t            id_opA,
    input  word_t            id_opB,
    output logic             ex_valid,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_aluSrc,
    output logic             ex_halt,
    output regbits_t         ex_rs,
    output regbits_t         ex_rt,
    output regbits_t         ex_dest,
    output aluop_t           ex_aluop,
    output word_t            ex_imm,
    output word_t            ex_pc,
    output word_t            ex_opA,
    output word_t            ex_opB,
    output logic             id_hold,
    output logic [CNT_W-1:0] bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    latch_state_t state, state_next;
    id_ex_ctrl_t  ctrl_q, ctrl_d;
    logic         valid_q;
    regbits_t     rs_q, rt_q, dest_q;
    word_t        imm_q, pc_q, opA_q, opB_q;
    logic [CNT_W-1:0] cnt_q;

    logic adv;
    logic lu;
    logic halted;
    logic take_bubble;
    logic count_bubble;

    load_use_detect u_lu (
        .ex_valid   (valid_q),
        .ex_memRead (ctrl_q.memRead),
        .ex_dest    (dest_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_usesRt  (id_usesRt),
        .lu         (lu)
    );

    assign adv    = ihit & ~mem_wait;
    assign halted = (state == HALTED);

    assign take_bubble = flush | halted | lu | ~id_valid;
    // Only flush and load-use bubbles are lost work. With flush highest
    // priority, a flush still counts while halted; a hazard while halted does not.
    assign count_bubble = flush | (~halted & lu);

    assign id_hold = lu | halted;

    assign ctrl_d = '{
        regWrite: id_regWrite,
        memRead:  id_memRead,
        memWrite: id_memWrite,
        aluSrc:   id_aluSrc,
        halt:     id_halt,
        aluop:    id_aluop
    };

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if ((state == RUN) && adv && !take_bubble && id_halt) begin
            state_next = HALTED;
        end
    end

    // ID -> EX register stage
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
        end else if (adv) begin
            if (take_bubble) begin
                valid_q     <= 1'b0;
                ctrl_q      <= '0;
                // Once halted, EX keeps signalling halt through every bubble.
                ctrl_q.halt <= halted;
                rs_q        <= '0;
                rt_q        <= '0;
                dest_q      <= '0;
                imm_q       <= '0;
                pc_q        <= '0;
                opA_q       <= '0;
                opB_q       <= '0;
            end else begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl_d;
                rs_q    <= id_rs;
                rt_q    <= id_rt;
                dest_q  <= id_dest;
                imm_q   <= id_imm;
                pc_q    <= id_pc;
                opA_q   <= id_opA;
                opB_q   <= id_opB;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (adv && count_bubble) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign ex_valid    = valid_q;
    assign ex_regWrite = ctrl_q.regWrite;
    assign ex_memRead  = ctrl_q.memRead;
    assign ex_memWrite = ctrl_q.memWrite;
    assign ex_aluSrc   = ctrl_q.aluSrc;
    assign ex_halt     = ctrl_q.halt;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dest     = dest_q;
    assign ex_imm      = imm_q;
    assign ex_pc       = pc_q;
    assign ex_opA      = opA_q;
    assign ex_opB      = opB_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     ihit, mem_wait, flush, id_valid;
    regbits_t id_rs, id_rt, id_dest;
    logic     id_usesRt, id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_halt;
    aluop_t   id_aluop;
    word_t    id_imm, id_pc, id_opA, id_opB;

    logic     ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_halt;
    regbits_t ex_rs, ex_rt, ex_dest;
    aluop_t   ex_aluop;
    word_t    ex_imm, ex_pc, ex_opA, ex_opB;
    logic     id_hold;
    logic [15:0] bubble_cnt;

    logic     s_valid, s_regWrite, s_memRead, s_memWrite, s_aluSrc, s_halt;
    regbits_t s_rs, s_rt, s_dest;
    aluop_t   s_aluop;
    word_t    s_imm, s_pc, s_opA, s_opB;
    logic     s_hold;
    logic [1:0] s_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    id_ex_latch #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_wait(mem_wait), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_usesRt(id_usesRt), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc), .id_halt(id_halt),
        .id_aluop(id_aluop), .id_imm(id_imm), .id_pc(id_pc), .id_opA(id_opA),
        .id_opB(id_opB), .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc),
        .ex_halt(ex_halt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_aluop(ex_aluop), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_opA(ex_opA),
        .ex_opB(ex_opB), .id_hold(id_hold), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    id_ex_latch #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_wait(mem_wait), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_usesRt(id_usesRt), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc), .id_halt(id_halt),
        .id_aluop(id_aluop), .id_imm(id_imm), .id_pc(id_pc), .id_opA(id_opA),
        .id_opB(id_opB), .ex_valid(s_valid), .ex_regWrite(s_regWrite),
        .ex_memRead(s_memRead), .ex_memWrite(s_memWrite), .ex_aluSrc(s_aluSrc),
        .ex_halt(s_halt), .ex_rs(s_rs), .ex_rt(s_rt), .ex_dest(s_dest),
        .ex_aluop(s_aluop), .ex_imm(s_imm), .ex_pc(s_pc), .ex_opA(s_opA),
        .ex_opB(s_opB), .id_hold(s_hold), .bubble_cnt(s_cnt)
    );

    typedef struct {
        string       tag;
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] opA;
        logic        halt;
        logic        hold;
        int          cnt;
        int          cnt_sat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Push the expected state after the coming edge, then let the edge happen.
    task automatic step(input string tag, input bit v, input int d, input int a,
                        input bit h, input bit hold, input int c, input int cs);
        exp_t e;
        e.tag = tag; e.valid = v; e.dest = d[4:0]; e.opA = a; e.halt = h;
        e.hold = hold; e.cnt = c; e.cnt_sat = cs;
        sb.push_back(e);
        @(negedge CLK);
        #2;
    endtask

    task automatic set_id(input int rs, input int rt, input int dest, input bit uses_rt,
                          input bit mem_rd, input bit halt, input int opa);
        id_valid   = 1'b1;
        id_rs      = rs[4:0];
        id_rt      = rt[4:0];
        id_dest    = dest[4:0];
        id_usesRt  = uses_rt;
        id_memRead = mem_rd;
        id_halt    = halt;
        id_opA     = opa;
        id_opB     = opa + 32'h1;
        id_imm     = 32'h4;
        id_pc      = 32'h100;
    endtask

    // Monitor: every edge where a vector was issued, compare EX against the head.
    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".ex_valid"},   {31'd0, ex_valid}, {31'd0, e.valid});
            chk({e.tag, ".ex_dest"},    {27'd0, ex_dest},  {27'd0, e.dest});
            chk({e.tag, ".ex_opA"},     ex_opA,            e.opA);
            chk({e.tag, ".ex_halt"},    {31'd0, ex_halt},  {31'd0, e.halt});
            chk({e.tag, ".id_hold"},    {31'd0, id_hold},  {31'd0, e.hold});
            chk({e.tag, ".bubble_cnt"}, {16'd0, bubble_cnt}, e.cnt);
            chk({e.tag, ".cnt_sat"},    {30'd0, s_cnt},    e.cnt_sat);
        end
    end

    initial begin
        nRST = 1'b0; ihit = 1'b0; mem_wait = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_dest = '0; id_usesRt = 1'b0;
        id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0;
        id_aluSrc = 1'b0; id_halt = 1'b0; id_aluop = ALU_ADD;
        id_imm = '0; id_pc = '0; id_opA = '0; id_opB = '0;
        repeat (2) @(negedge CLK);
        #2;
        chk("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("reset.id_hold", {31'd0, id_hold}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        #2;

        // Normal capture
        ihit = 1'b1; id_regWrite = 1'b1;
        set_id(1, 2, 8, 1, 0, 0, 32'h10);
        step("capture", 1, 8, 32'h10, 0, 0, 0, 0);

        // Load into EX, then a dependent instruction on rt
        set_id(1, 2, 9, 1, 1, 0, 32'h20);
        step("lw9", 1, 9, 32'h20, 0, 0, 0, 0);
        set_id(3, 9, 10, 1, 0, 0, 32'h30);
        #1;
        chk("lu_rt.id_hold_pre", {31'd0, id_hold}, 32'd1);
        step("lu_rt.bubble", 0, 0, 0, 0, 0, 1, 1);
        step("lu_rt.retry", 1, 10, 32'h30, 0, 0, 1, 1);

        // Load to r0 never stalls
        set_id(0, 0, 0, 1, 1, 0, 32'h40);
        step("lw0", 1, 0, 32'h40, 0, 0, 1, 1);
        set_id(0, 0, 11, 1, 0, 0, 32'h50);
        #1;
        chk("lu_r0.id_hold_pre", {31'd0, id_hold}, 32'd0);
        step("lu_r0.load", 1, 11, 32'h50, 0, 0, 1, 1);

        // rt match without usesRt never stalls
        set_id(0, 0, 12, 1, 1, 0, 32'h60);
        step("lw12", 1, 12, 32'h60, 0, 0, 1, 1);
        set_id(4, 12, 13, 0, 0, 0, 32'h70);
        #1;
        chk("lu_nort.id_hold_pre", {31'd0, id_hold}, 32'd0);
        step("lu_nort.load", 1, 13, 32'h70, 0, 0, 1, 1);

        // mem_wait freezes the latch for three cycles
        mem_wait = 1'b1;
        set_id(0, 0, 14, 1, 0, 0, 32'h80);
        for (int i = 0; i < 3; i++) step("mem_wait", 1, 13, 32'h70, 0, 0, 1, 1);
        mem_wait = 1'b0;

        // Flush coinciding with load-use: one bubble, one count, no extra stall
        set_id(0, 0, 15, 1, 1, 0, 32'h90);
        step("lw15", 1, 15, 32'h90, 0, 0, 1, 1);
        set_id(15, 0, 16, 0, 0, 0, 32'hA0);
        flush = 1'b1;
        #1;
        chk("flush_lu.id_hold_pre", {31'd0, id_hold}, 32'd1);
        step("flush_lu.bubble", 0, 0, 0, 0, 0, 2, 2);
        flush = 1'b0;
        step("flush_lu.next", 1, 16, 32'hA0, 0, 0, 2, 2);

        // Empty ID: bubble, not counted
        id_valid = 1'b0;
        step("empty_id", 0, 0, 0, 0, 0, 2, 2);

        // Three flushes, narrow counter saturates
        set_id(0, 0, 17, 1, 0, 0, 32'hB0);
        flush = 1'b1;
        step("flush_a", 0, 0, 0, 0, 0, 3, 3);
        step("flush_b", 0, 0, 0, 0, 0, 4, 3);
        step("flush_c", 0, 0, 0, 0, 0, 5, 3);
        flush = 1'b0;
        step("load17", 1, 17, 32'hB0, 0, 0, 5, 3);

        // Asynchronous reset mid-cycle
        nRST = 1'b0;
        #1;
        chk("async_rst.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("async_rst.ex_dest", {27'd0, ex_dest}, 32'd0);
        chk("async_rst.ex_opA", ex_opA, 32'd0);
        chk("async_rst.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("async_rst.cnt_sat", {30'd0, s_cnt}, 32'd0);
        chk("async_rst.id_hold", {31'd0, id_hold}, 32'd0);
        @(negedge CLK);
        #2;
        nRST = 1'b1;

        // Five flushes after reset: narrow counter sticks at 3
        flush = 1'b1;
        step("sat1", 0, 0, 0, 0, 0, 1, 1);
        step("sat2", 0, 0, 0, 0, 0, 2, 2);
        step("sat3", 0, 0, 0, 0, 0, 3, 3);
        step("sat4", 0, 0, 0, 0, 0, 4, 3);
        step("sat5", 0, 0, 0, 0, 0, 5, 3);
        flush = 1'b0;

        // Halt: sticky, further advances insert uncounted bubbles with halt held
        set_id(0, 0, 18, 1, 0, 1, 32'hC0);
        step("halt.load", 1, 18, 32'hC0, 1, 1, 5, 3);
        set_id(0, 0, 19, 1, 0, 0, 32'hD0);
        step("halt.bubble1", 0, 0, 0, 1, 1, 5, 3);
        ihit = 1'b0;
        step("halt.noihit", 0, 0, 0, 1, 1, 5, 3);
        ihit = 1'b1;
        step("halt.bubble2", 0, 0, 0, 1, 1, 5, 3);

        @(negedge CLK);
        #2;
        chk("scoreboard.drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
